ws2812_frame_streamer: RTL and testbench



---
 rtl/ws2812_pkg.sv | 25 ++
 rtl/ws2812_bit_timer.sv | 51 +++++
 rtl/ws2812_frame_streamer.sv | 168 ++++++++++++++++
 tb/tb_ws2812_frame_streamer.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared types, default timing and helpers for the WS2812 frame streamer.
// Default timing assumes a 10 MHz clock (100 ns per cycle).
package ws2812_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SEND  = 3'd3,
    ST_LATCH = 3'd4,
    ST_DONE  = 3'd5
  } ws2812_state_t;

  // 0.4 us / 0.8 us high, 1.3 us bit period, 60 us latch at 10 MHz
  localparam int WS2812_T0H_CYC   = 4;
  localparam int WS2812_T1H_CYC   = 8;
  localparam int WS2812_BIT_CYC   = 13;
  localparam int WS2812_LATCH_CYC = 600;

  // High-time of a bit cell, selected by the bit value
  function automatic int ws2812_high_cyc(input logic bit_v, input int t0h, input int t1h);
    return bit_v ? t1h : t0h;
  endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Bit-cell timer: counts BIT_CYC cycles per bit, flags the first and last
// cycle of each cell and tells the parent whether the line should be high
// in the next cycle of the same cell.
module ws2812_bit_timer
  import ws2812_pkg::*;
#(
  parameter int T0H_CYC = WS2812_T0H_CYC,
  parameter int T1H_CYC = WS2812_T1H_CYC,
  parameter int BIT_CYC = WS2812_BIT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic bit_i,
  output logic bit_first_o,
  output logic bit_last_o,
  output logic hi_next_o
);

  localparam int CW = $clog2(BIT_CYC);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_first_o = en_i && (cnt_q == '0);
  assign bit_last_o  = en_i && (cnt_q == CW'(BIT_CYC - 1));
  // dout is registered, so the decision is made one cycle ahead
  assign hi_next_o   = (int'(cnt_q) + 1) < ws2812_high_cyc(bit_i, T0H_CYC, T1H_CYC);

  // Next cell position: hold at zero while disabled, wrap at the end of a cell
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (bit_last_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Cell position register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ws2812_frame_streamer.sv
// WS2812 frame streamer: reads NUM_BYTES bytes from a synchronous RAM and
// serialises them MSB-first with NRZ bit timing, then holds the line low
// for the latch interval and pulses done.
// Optional macro WS2812_LOOP_EN: restart the frame from byte 0 after every
// DONE (continuous refresh, only rst stops it).
module ws2812_frame_streamer
  import ws2812_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int NUM_BYTES = 24,
  parameter int T0H_CYC   = WS2812_T0H_CYC,
  parameter int T1H_CYC   = WS2812_T1H_CYC,
  parameter int BIT_CYC   = WS2812_BIT_CYC,
  parameter int LATCH_CYC = WS2812_LATCH_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_data,
  output logic              dout,
  output logic              busy,
  output logic              done
);

  localparam int BW = ADDR_W + 1;
  localparam int LW = $clog2(LATCH_CYC + 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES - 1);

  ws2812_state_t     state_q;
  logic [BW-1:0]     byte_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
  logic [7:0]        next_q;
  logic [ADDR_W-1:0] addr_q;
  logic              pf_addr_q;
  logic              pf_cap_q;
  logic [LW-1:0]     lat_q;
  logic              dout_q;
  logic              busy_q;
  logic              done_q;

  logic bit_first_s;
  logic bit_last_s;
  logic hi_next_s;
  logic last_byte_s;

  assign last_byte_s = (byte_q == LAST_BYTE);
  assign ram_addr    = addr_q;
  assign dout        = dout_q;
  assign busy        = busy_q;
  assign done        = done_q;

  ws2812_bit_timer #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .BIT_CYC (BIT_CYC)
  ) u_bit_timer (
    .clk         (clk),
    .rst         (rst),
    .en_i        (state_q == ST_SEND),
    .bit_i       (shift_q[7]),
    .bit_first_o (bit_first_s),
    .bit_last_o  (bit_last_s),
    .hi_next_o   (hi_next_s)
  );

  // Frame sequencer with registered line, address, busy and done outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      byte_q    <= '0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      next_q    <= 8'h00;
      addr_q    <= '0;
      pf_addr_q <= 1'b0;
      pf_cap_q  <= 1'b0;
      lat_q     <= '0;
      dout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      pf_addr_q <= 1'b0;
      // RAM data for a prefetched address arrives one cycle after the address
      pf_cap_q  <= pf_addr_q;
      case (state_q)
        ST_IDLE: begin
          dout_q <= 1'b0;
          addr_q <= '0;
          if (start) begin
            state_q <= ST_FETCH;
            busy_q  <= 1'b1;
            byte_q  <= '0;
            bit_q   <= 3'd0;
          end
        end
        ST_FETCH: begin
          state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          shift_q <= ram_data;
          // Every bit cell opens with a high phase
          dout_q  <= 1'b1;
          state_q <= ST_SEND;
        end
        ST_SEND: begin
          if (bit_first_s && (bit_q == 3'd7) && !last_byte_s) begin
            addr_q    <= addr_q + ADDR_W'(1);
            pf_addr_q <= 1'b1;
          end
          if (pf_cap_q) begin
            next_q <= ram_data;
          end
          if (bit_last_s) begin
            if (bit_q == 3'd7) begin
              bit_q <= 3'd0;
              if (last_byte_s) begin
                state_q <= ST_LATCH;
                dout_q  <= 1'b0;
                lat_q   <= '0;
              end else begin
                byte_q  <= byte_q + BW'(1);
                // Very short bit cells can land the capture on this same edge
                shift_q <= pf_cap_q ? ram_data : next_q;
                dout_q  <= 1'b1;
              end
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {shift_q[6:0], 1'b0};
              dout_q  <= 1'b1;
            end
          end else begin
            dout_q <= hi_next_s;
          end
        end
        ST_LATCH: begin
          dout_q <= 1'b0;
          if (lat_q == LW'(LATCH_CYC - 1)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            lat_q <= lat_q + LW'(1);
          end
        end
        ST_DONE: begin
          lat_q  <= '0;
          addr_q <= '0;
          byte_q <= '0;
          bit_q  <= 3'd0;
`ifdef WS2812_LOOP_EN
          state_q <= ST_FETCH;
`else
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
`endif
        end
        default: begin
          state_q <= ST_IDLE;
          dout_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_frame_streamer.sv
// Directed bench for ws2812_frame_streamer: a 3-byte frame (0x80, 0x00, 0xFF),
// ignored mid-frame start, mid-frame reset, a 256-byte frame and, when
// WS2812_LOOP_EN is defined, continuous refresh.
module tb_ws2812_frame_streamer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] ram_addr;
  logic [7:0] ram_data;
  logic       dout;
  logic       busy;
  logic       done;

  logic       start_b;
  logic [7:0] addr_b;
  logic [7:0] data_b;
  logic       dout_b;
  logic       busy_b;
  logic       done_b;

  logic [7:0] mem_s [0:255];
  logic [7:0] mem_b [0:255];

  int checks;
  int errors;

  ws2812_frame_streamer #(.ADDR_W(8), .NUM_BYTES(3)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .dout     (dout),
    .busy     (busy),
    .done     (done)
  );

  ws2812_frame_streamer #(.ADDR_W(8), .NUM_BYTES(256)) u_big (
    .clk      (clk),
    .rst      (rst),
    .start    (start_b),
    .ram_addr (addr_b),
    .ram_data (data_b),
    .dout     (dout_b),
    .busy     (busy_b),
    .done     (done_b)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  always @(posedge clk) begin
    ram_data <= mem_s[ram_addr];
    data_b   <= mem_b[addr_b];
  end

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    start_b = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (dout !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ram_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: dout=%b busy=%b done=%b addr=%h, expected 0 0 0 00", dout, busy, done, ram_addr);
    end
    checks++;
    if (dout_b !== 1'b0 || busy_b !== 1'b0 || addr_b !== 8'h00) begin
      errors++;
      $display("FAIL reset_state_big: dout=%b busy=%b addr=%h, expected 0 0 00", dout_b, busy_b, addr_b);
    end
    start = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Full 3-byte frame; optionally re-pulses start at cycle pulse_at
  task automatic run_frame(input int pulse_at, input string tag);
    logic [7:0] exp_bytes [3];
    logic prev_d;
    logic exp_bit;
    int rises, hi_len, latch_hi, done_cnt, done_at, busy_bad, busy_after;
    int n_addr, prev_addr, bidx;
    int addr_seq [4];
    exp_bytes[0] = 8'h80;
    exp_bytes[1] = 8'h00;
    exp_bytes[2] = 8'hFF;
    rises = 0; hi_len = 0; latch_hi = 0; done_cnt = 0; done_at = -1;
    busy_bad = 0; busy_after = 0; n_addr = 0; prev_addr = -1; prev_d = 1'b0;
    for (int i = 0; i < 4; i++) addr_seq[i] = -1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 960; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == pulse_at) start = 1'b1;
      if (k == pulse_at + 1) start = 1'b0;
      if (k == 1) begin
        checks++;
        if (busy !== 1'b1 || ram_addr !== 8'h00) begin
          errors++;
          $display("FAIL %s first_cycle: busy=%b addr=%h, expected 1 00", tag, busy, ram_addr);
        end
      end
      if (dout === 1'b1 && prev_d === 1'b0) begin
        checks++;
        if (k != 3 + 13 * rises) begin
          errors++;
          $display("FAIL %s rise_pos bit%0d: cycle %0d, expected %0d", tag, rises, k, 3 + 13 * rises);
        end
        rises++;
        hi_len = 0;
      end
      if (dout === 1'b1) hi_len++;
      if (dout === 1'b0 && prev_d === 1'b1) begin
        bidx = rises - 1;
        if (bidx < 24) begin
          exp_bit = exp_bytes[bidx / 8][7 - (bidx % 8)];
          checks++;
          if (hi_len != (exp_bit ? 8 : 4)) begin
            errors++;
            $display("FAIL %s high_width bit%0d: %0d cycles, expected %0d", tag, bidx, hi_len, exp_bit ? 8 : 4);
          end
        end
      end
      if (k >= 315 && k <= 914 && dout !== 1'b0) latch_hi++;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = k;
      end
      if (k <= 915 && busy !== 1'b1) busy_bad++;
      if (k >= 916 && busy !== 1'b0) busy_after++;
      if (k <= 915 && int'(ram_addr) != prev_addr) begin
        if (n_addr < 4) addr_seq[n_addr] = int'(ram_addr);
        n_addr++;
        prev_addr = int'(ram_addr);
      end
      if (k == 916) begin
        checks++;
        if (ram_addr !== 8'h00) begin
          errors++;
          $display("FAIL %s idle_addr: %h, expected 00", tag, ram_addr);
        end
      end
      prev_d = dout;
    end
    checks++;
    if (rises != 24) begin
      errors++;
      $display("FAIL %s rise_count: %0d, expected 24", tag, rises);
    end
    checks++;
    if (latch_hi != 0) begin
      errors++;
      $display("FAIL %s latch_low: %0d high cycles, expected 0", tag, latch_hi);
    end
    checks++;
    if (done_cnt != 1 || done_at != 915) begin
      errors++;
      $display("FAIL %s done_pulse: count %0d at cycle %0d, expected 1 at 915", tag, done_cnt, done_at);
    end
    checks++;
    if (busy_bad != 0 || busy_after != 0) begin
      errors++;
      $display("FAIL %s busy_window: %0d low in frame, %0d high after, expected 0 0", tag, busy_bad, busy_after);
    end
    checks++;
    if (n_addr != 3 || addr_seq[0] != 0 || addr_seq[1] != 1 || addr_seq[2] != 2) begin
      errors++;
      $display("FAIL %s addr_seq: n=%0d %0d,%0d,%0d expected n=3 0,1,2", tag, n_addr, addr_seq[0], addr_seq[1], addr_seq[2]);
    end
  endtask

  task automatic test_frame();
    run_frame(-10, "frame");
  endtask

  task automatic test_start_ignored();
    run_frame(100, "start_busy");
  endtask

  task automatic test_reset_mid();
    int hit;
    hit = -1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 200 && hit < 0; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k >= 50 && dout === 1'b1) begin
        hit = k;
        rst = 1'b1;
      end
    end
    // bit 4 of 0x80 (a 0) opens at cycle 3 + 4*13 = 55
    checks++;
    if (hit != 55) begin
      errors++;
      $display("FAIL rst_mid high_cycle: %0d, expected 55", hit);
    end
    @(negedge clk);
    checks++;
    if (dout !== 1'b0 || busy !== 1'b0 || ram_addr !== 8'h00 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid outputs: dout=%b busy=%b addr=%h done=%b, expected 0 0 00 0", dout, busy, ram_addr, done);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_frame(-10, "after_rst");
  endtask

  task automatic test_big();
    logic prev_d;
    logic [7:0] cur;
    int hi_len, rises, nbits, bad_pos, bad_w, bad_byte, wraps, prev_a, done_at;
    prev_d = 1'b0; cur = 8'h00; hi_len = 0; rises = 0; nbits = 0;
    bad_pos = 0; bad_w = 0; bad_byte = 0; wraps = 0; prev_a = 0; done_at = -1;
    @(negedge clk);
    start_b = 1'b1;
    for (int k = 1; k <= 27240; k++) begin
      @(negedge clk);
      if (k == 1) start_b = 1'b0;
      if (dout_b === 1'b1 && prev_d === 1'b0) begin
        if (k != 3 + 13 * rises) bad_pos++;
        rises++;
        hi_len = 0;
      end
      if (dout_b === 1'b1) hi_len++;
      if (dout_b === 1'b0 && prev_d === 1'b1) begin
        if (hi_len != 4 && hi_len != 8) bad_w++;
        cur = {cur[6:0], (hi_len == 8)};
        nbits++;
        if (nbits % 8 == 0 && cur != 8'(nbits / 8 - 1)) bad_byte++;
      end
      if (k <= 27227) begin
        if (int'(addr_b) < prev_a) wraps++;
        prev_a = int'(addr_b);
      end
      if (k == 27227) begin
        checks++;
        if (addr_b !== 8'hFF) begin
          errors++;
          $display("FAIL big last_addr: %h, expected ff", addr_b);
        end
      end
      if (done_b === 1'b1 && done_at < 0) done_at = k;
      prev_d = dout_b;
    end
    checks++;
    if (rises != 2048 || nbits != 2048) begin
      errors++;
      $display("FAIL big bit_count: rises %0d bits %0d, expected 2048", rises, nbits);
    end
    checks++;
    if (bad_pos != 0 || bad_w != 0) begin
      errors++;
      $display("FAIL big timing: %0d bad rises %0d bad widths, expected 0 0", bad_pos, bad_w);
    end
    checks++;
    if (bad_byte != 0) begin
      errors++;
      $display("FAIL big byte_order: %0d wrong bytes, expected 0", bad_byte);
    end
    checks++;
    if (wraps != 0) begin
      errors++;
      $display("FAIL big addr_wrap: %0d decreases, expected 0", wraps);
    end
    checks++;
    if (done_at != 27227) begin
      errors++;
      $display("FAIL big done_cycle: %0d, expected 27227", done_at);
    end
  endtask

  task automatic test_loop();
    int done_at [2];
    int nd, busy_low;
    nd = 0; busy_low = 0; done_at[0] = -1; done_at[1] = -1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 1900; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done === 1'b1) begin
        if (nd < 2) done_at[nd] = k;
        nd++;
      end
      if (busy !== 1'b1) busy_low++;
      if (k == 916) begin
        checks++;
        if (ram_addr !== 8'h00 || dout !== 1'b0) begin
          errors++;
          $display("FAIL loop refetch: addr=%h dout=%b, expected 00 0", ram_addr, dout);
        end
      end
      if (k == 918) begin
        checks++;
        if (dout !== 1'b1) begin
          errors++;
          $display("FAIL loop first_rise: dout=%b at 918, expected 1", dout);
        end
      end
    end
    checks++;
    if (nd != 2 || done_at[0] != 915 || done_at[1] != 1830) begin
      errors++;
      $display("FAIL loop done_pulses: n=%0d at %0d,%0d expected 2 at 915,1830", nd, done_at[0], done_at[1]);
    end
    checks++;
    if (busy_low != 0) begin
      errors++;
      $display("FAIL loop busy: %0d low cycles, expected 0", busy_low);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dout !== 1'b0) begin
      errors++;
      $display("FAIL loop stop: busy=%b dout=%b, expected 0 0", busy, dout);
    end
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    start = 1'b0;
    start_b = 1'b0;
    mem_s[0] = 8'h80;
    mem_s[1] = 8'h00;
    mem_s[2] = 8'hFF;
    for (int i = 3; i < 256; i++) mem_s[i] = 8'h55;
    for (int i = 0; i < 256; i++) mem_b[i] = 8'(i);
    test_reset();
`ifdef WS2812_LOOP_EN
    test_loop();
`else
    test_frame();
    test_start_ignored();
    test_reset_mid();
    test_big();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
